// File: rtl/fpga_mux_pkg.sv
// Shared width helpers for the configurable routing mux bank.
package fpga_mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Select width never drops below one bit, even for degenerate sizes.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Counter must hold 0..total+1 so over-shift is distinguishable from exact.
  function automatic int cnt_w(input int total);
    return sel_w(total + 2);
  endfunction

endpackage

// File: rtl/cfg_mux_slice.sv
// One N_IN-input routing mux; output register present when FPGA_MUX_OUT_REG_EN is defined.
module cfg_mux_slice
  import fpga_mux_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int SEL_W = sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  logic y;

  // Explicit compare chain keeps out-of-range codes harmless even though the
  // bank never commits one.
  always_comb begin
    y = in_vec[0];
    for (int i = 1; i < N_IN; i++)
      if (sel == SEL_W'(i)) y = in_vec[i];
  end

`ifdef FPGA_MUX_OUT_REG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) out <= 1'b0;
    else     out <= y;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = ^{clk, rst};
  assign out = y;
`endif

endmodule

// File: rtl/fpga_cfg_mux_bank.sv
// Bank of scan-configured routing muxes with double-buffered, validated commit.
// Define FPGA_MUX_OUT_REG_EN to register the mux outputs.
module fpga_cfg_mux_bank
  import fpga_mux_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int NUM_MUX = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_en,
  input  logic                    cfg_in,
  output logic                    cfg_out,
  input  logic                    cfg_commit,
  input  logic [NUM_MUX*N_IN-1:0] in,
  output logic [NUM_MUX-1:0]      out,
  output logic                    cfg_loaded,
  output logic                    cfg_err
);

  localparam int SEL_W      = sel_w(N_IN);
  localparam int TOTAL_BITS = NUM_MUX * SEL_W;
  localparam int CNT_W      = cnt_w(TOTAL_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL_BITS + 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_IN);

  logic [TOTAL_BITS-1:0]          sr;
  logic [TOTAL_BITS:0]            sr_ext;
  logic [CNT_W-1:0]               cnt;
  logic [NUM_MUX-1:0][SEL_W-1:0]  act_sel;
  logic                           fields_ok;
  logic                           accept;

  assign sr_ext  = {cfg_in, sr};
  assign cfg_out = sr[0];

  // For power-of-two N_IN every code is below N_LIM, so this folds to 1.
  always_comb begin
    fields_ok = 1'b1;
    for (int k = 0; k < NUM_MUX; k++)
      if ({1'b0, sr[k*SEL_W +: SEL_W]} >= N_LIM) fields_ok = 1'b0;
  end

  assign accept = (cnt == CNT_FULL) && fields_ok;

  // Commit wins over shift; it judges the pre-edge shift register and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      cnt        <= '0;
      act_sel    <= '0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (cfg_commit) begin
      cnt <= '0;
      if (accept) begin
        act_sel    <= sr;
        cfg_loaded <= 1'b1;
        cfg_err    <= 1'b0;
      end else begin
        cfg_err    <= 1'b1;
      end
    end else if (cfg_en) begin
      sr <= sr_ext[TOTAL_BITS:1];
      if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_MUX; k++) begin : g_mux
    cfg_mux_slice #(
      .N_IN  (N_IN),
      .SEL_W (SEL_W)
    ) u_slice (
      .clk    (clk),
      .rst    (reset),
      .in_vec (in[k*N_IN +: N_IN]),
      .sel    (act_sel[k]),
      .out    (out[k])
    );
  end

endmodule

// File: tb/tb_fpga_cfg_mux_bank.sv
// Directed bench for fpga_cfg_mux_bank (N_IN=5, NUM_MUX=2, combinational build).
module tb_fpga_cfg_mux_bank;

  localparam int N_IN    = 5;
  localparam int NUM_MUX = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    cfg_en;
  logic                    cfg_in;
  logic                    cfg_out;
  logic                    cfg_commit;
  logic [NUM_MUX*N_IN-1:0] din;
  logic [NUM_MUX-1:0]      out;
  logic                    cfg_loaded;
  logic                    cfg_err;

  int total = 0;
  int bad   = 0;

  fpga_cfg_mux_bank #(.N_IN(N_IN), .NUM_MUX(NUM_MUX)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .in         (din),
    .out        (out),
    .cfg_loaded (cfg_loaded),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Shift v LSB-first for n cycles; inputs change on negedge, so the
  // caller sits on a negedge before and after.
  task automatic shift_vec(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_in = v[i % 6];
      @(negedge clk);
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    din = 10'b0000100001;
    @(negedge clk); @(negedge clk);
    total++; if (out !== 2'b11) begin bad++; $display("FAIL reset_out got=%b exp=11", out); end
    total++; if (cfg_loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b exp=0", cfg_loaded); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    total++; if (cfg_out !== 1'b0) begin bad++; $display("FAIL reset_cfg_out got=%b exp=0", cfg_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    shift_vec(6'b100_011, 6);  // mux0=3, mux1=4
    commit();
    total++; if (cfg_loaded !== 1'b1) begin bad++; $display("FAIL load_loaded got=%b exp=1", cfg_loaded); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL load_err got=%b exp=0", cfg_err); end
    din = 10'b1000001000;
    @(negedge clk);
    total++; if (out !== 2'b11) begin bad++; $display("FAIL load_out got=%b exp=11", out); end
    din[3] = 1'b0;
    #1;
    total++; if (out !== 2'b10) begin bad++; $display("FAIL load_toggle got=%b exp=10", out); end
    din[3] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_shift();
    shift_vec(6'b000_000, 5);
    commit();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", cfg_err); end
    total++; if (cfg_loaded !== 1'b1) begin bad++; $display("FAIL short_loaded got=%b exp=1", cfg_loaded); end
    total++; if (out !== 2'b11) begin bad++; $display("FAIL short_out got=%b exp=11", out); end
    shift_vec(6'b010_001, 6);  // mux0=1, mux1=2
    commit();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reload_err got=%b exp=0", cfg_err); end
    din = 10'b0010000010;
    #1;
    total++; if (out !== 2'b11) begin bad++; $display("FAIL reload_out got=%b exp=11", out); end
  endtask

  task automatic test_over_shift();
    shift_vec(6'b010_001, 7);
    commit();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL over_err got=%b exp=1", cfg_err); end
  endtask

  task automatic test_illegal_field();
    shift_vec(6'b000_111, 6);  // mux0=7
    commit();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL illegal0_err got=%b exp=1", cfg_err); end
    total++; if (out !== 2'b11) begin bad++; $display("FAIL illegal0_out got=%b exp=11", out); end
    shift_vec(6'b101_000, 6);  // mux1=5
    commit();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL illegal1_err got=%b exp=1", cfg_err); end
    total++; if (out !== 2'b11) begin bad++; $display("FAIL illegal1_out got=%b exp=11", out); end
  endtask

  task automatic test_priority_chain();
    shift_vec(6'b011_010, 6);  // mux0=2, mux1=3
    cfg_en = 1'b1; cfg_in = 1'b1;
    commit();
    cfg_en = 1'b0; cfg_in = 1'b0;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL prio_err got=%b exp=0", cfg_err); end
    total++; if (cfg_out !== 1'b0) begin bad++; $display("FAIL prio_no_shift got=%b exp=0", cfg_out); end
    din = 10'b0100000100;
    #1;
    total++; if (out !== 2'b11) begin bad++; $display("FAIL prio_out got=%b exp=11", out); end
    commit();  // counter was cleared, so this one must bounce
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL prio_cnt_err got=%b exp=1", cfg_err); end
    shift_vec(6'b110_101, 5);
    total++; if (cfg_out !== 1'b0) begin bad++; $display("FAIL chain5 got=%b exp=0", cfg_out); end
    shift_vec(6'b101_011, 1);  // sixth shift; bit value irrelevant to cfg_out
    total++; if (cfg_out !== 1'b1) begin bad++; $display("FAIL chain6 got=%b exp=1", cfg_out); end
    total++; if (out !== 2'b11) begin bad++; $display("FAIL chain_out got=%b exp=11", out); end
  endtask

  task automatic test_reset_mid_shift();
    shift_vec(6'b000_111, 3);
    reset = 1'b1;
    din = 10'b0000100001;
    #1;
    total++; if (cfg_out !== 1'b0) begin bad++; $display("FAIL rst_mid_cfg_out got=%b exp=0", cfg_out); end
    total++; if (cfg_loaded !== 1'b0) begin bad++; $display("FAIL rst_mid_loaded got=%b exp=0", cfg_loaded); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%b exp=0", cfg_err); end
    total++; if (out !== 2'b11) begin bad++; $display("FAIL rst_mid_out got=%b exp=11", out); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    shift_vec(6'b001_100, 3);  // mux0=4, mux1=1
    total++; if (cfg_out !== 1'b0) begin bad++; $display("FAIL rst_mid_sr got=%b exp=0", cfg_out); end
    shift_vec(6'b001_100 >> 3, 3);
    commit();
    total++; if (cfg_loaded !== 1'b1) begin bad++; $display("FAIL rst_reload_loaded got=%b exp=1", cfg_loaded); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_reload_err got=%b exp=0", cfg_err); end
    din = 10'b0001010000;
    #1;
    total++; if (out !== 2'b11) begin bad++; $display("FAIL rst_reload_out got=%b exp=11", out); end
  endtask

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_full_load();
    test_short_shift();
    test_over_shift();
    test_illegal_field();
    test_priority_chain();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
